// File: rtl/serial_burst_seq.sv
// Burst word sequencer in front of the 3-wire serial duplex controller.
// Feeds TX words out, captures looped-back RX words, reports done/error.
module serial_burst_seq #(
  parameter int BITS       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_BITS   = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic [LEN_BITS-1:0] in_len,
  input  logic [BITS-1:0]     in_tx_data,
  input  logic                in_tx_valid,
  output logic                out_tx_ready,
  output logic [BITS-1:0]     out_rx_data,
  output logic                out_rx_valid,
  input  logic                in_rx_ready,
  output logic                out_enable,
  output logic [BITS-1:0]     out_word,
  input  logic                in_next_word,
  input  logic                in_word_finished,
  input  logic [BITS-1:0]     in_rx_word,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_error,
  output logic                out_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t state_q, state_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic enable_q, enable_d;
  logic [BITS-1:0] word_q, word_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic ovf_q, ovf_d;

  logic [2:0] nw_sync_q, wf_sync_q;
  logic nw_edge_q, wf_edge_q;

  logic [BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q;
  logic [CW-1:0] tx_cnt_q;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic [BITS-1:0] tx_head;

  logic [BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q;
  logic [CW-1:0] rx_cnt_q;
  logic rx_full, rx_push, rx_pop;

  // Serial-domain strobes: two sync flops, then a registered rise detect
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      nw_sync_q <= '0;
      wf_sync_q <= '0;
      nw_edge_q <= 1'b0;
      wf_edge_q <= 1'b0;
    end else begin
      nw_sync_q <= {nw_sync_q[1:0], in_next_word};
      wf_sync_q <= {wf_sync_q[1:0], in_word_finished};
      nw_edge_q <= nw_sync_q[1] & ~nw_sync_q[2];
      wf_edge_q <= wf_sync_q[1] & ~wf_sync_q[2];
    end
  end

  assign tx_full      = tx_cnt_q == CW'(FIFO_DEPTH);
  assign tx_empty     = tx_cnt_q == '0;
  assign out_tx_ready = in_rst & ~tx_full;
  assign tx_push      = in_tx_valid & out_tx_ready;
  assign tx_head      = tx_mem[tx_rd_q];

  always_ff @(posedge in_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= in_tx_data;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
    end
  end

  assign rx_full      = rx_cnt_q == CW'(FIFO_DEPTH);
  assign out_rx_valid = rx_cnt_q != '0;
  assign out_rx_data  = out_rx_valid ? rx_mem[rx_rd_q] : '0;
  assign rx_pop       = out_rx_valid & in_rx_ready;

  always_ff @(posedge in_clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= in_rx_word;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      enable_q <= 1'b0;
      word_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      enable_q <= enable_d;
      word_q   <= word_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    enable_d = enable_q;
    word_d   = word_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    ovf_d    = ovf_q;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          error_d = 1'b0;
          ovf_d   = 1'b0;
          if (in_len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = in_len;
            busy_d  = 1'b1;
            state_d = S_PRIME;
          end
        end
      end
      S_PRIME: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          word_d   = tx_head;
          enable_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Word-finished works on the remaining count before this cycle
        if (wf_edge_q) begin
          if (rx_full) ovf_d = 1'b1;
          else         rx_push = 1'b1;
          rem_d = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
            enable_d = 1'b0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end
        if (nw_edge_q && rem_q > LEN_BITS'(1)) begin
          if (tx_empty) begin
            enable_d = 1'b0;
            error_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            tx_pop = 1'b1;
            word_d = tx_head;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_enable   = enable_q;
  assign out_word     = word_q;
  assign out_busy     = busy_q;
  assign out_done     = done_q;
  assign out_error    = error_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_serial_burst_seq.sv
// Bench for serial_burst_seq: loopback serial model, vector table,
// plus directed overflow, busy-start and mid-burst reset sequences.
module tb_serial_burst_seq;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       in_start = 1'b0;
  logic [7:0] in_len = '0;
  logic [7:0] in_tx_data = '0;
  logic       in_tx_valid = 1'b0;
  logic       out_tx_ready;
  logic [7:0] out_rx_data;
  logic       out_rx_valid;
  logic       in_rx_ready = 1'b0;
  logic       out_enable;
  logic [7:0] out_word;
  logic       in_next_word = 1'b0;
  logic       in_word_finished = 1'b0;
  logic [7:0] in_rx_word = '0;
  logic       out_busy;
  logic       out_done;
  logic       out_error;
  logic       out_overflow;

  serial_burst_seq #(
    .BITS(8),
    .FIFO_DEPTH(4),
    .LEN_BITS(8)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_start(in_start),
    .in_len(in_len),
    .in_tx_data(in_tx_data),
    .in_tx_valid(in_tx_valid),
    .out_tx_ready(out_tx_ready),
    .out_rx_data(out_rx_data),
    .out_rx_valid(out_rx_valid),
    .in_rx_ready(in_rx_ready),
    .out_enable(out_enable),
    .out_word(out_word),
    .in_next_word(in_next_word),
    .in_word_finished(in_word_finished),
    .in_rx_word(in_rx_word),
    .out_busy(out_busy),
    .out_done(out_done),
    .out_error(out_error),
    .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  bit en_prev = 1'b0;
  logic [7:0] sent_q[$];

  always @(negedge in_clk) begin
    if (out_done) done_cnt++;
    if (out_enable && !en_prev) rise_cnt++;
    en_prev = out_enable;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Serial side: each word spans ~19 main cycles, every level >= 4 cycles
  task automatic wait_cyc(input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge in_clk);
      if (!out_enable) ab = 1'b1;
    end
  endtask

  initial begin : serial_model
    logic [7:0] cur;
    bit ab;
    forever begin
      @(negedge in_clk);
      while (out_enable) begin
        cur = out_word;
        sent_q.push_back(cur);
        wait_cyc(3, ab);
        if (ab) break;
        in_next_word = 1'b1;
        wait_cyc(4, ab);
        in_next_word = 1'b0;
        if (ab) break;
        wait_cyc(4, ab);
        if (ab) break;
        in_rx_word = cur;
        in_word_finished = 1'b1;
        wait_cyc(4, ab);
        in_word_finished = 1'b0;
        if (ab) break;
        wait_cyc(4, ab);
        if (ab) break;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!out_tx_ready && n < 500) begin
      @(negedge in_clk);
      n++;
    end
    if (n >= 500) chk("push_timeout", 32'd1, 32'd0);
    in_tx_data  = d;
    in_tx_valid = 1'b1;
    @(negedge in_clk);
    in_tx_valid = 1'b0;
  endtask

  task automatic start(input int len);
    in_len   = 8'(len);
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, "_valid"}, out_rx_valid, 1);
    chk({nm, "_data"}, out_rx_data, exp);
    in_rx_ready = 1'b1;
    @(negedge in_clk);
    in_rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (out_busy && n < 3000) begin
      @(negedge in_clk);
      n++;
    end
    chk({nm, "_idle"}, out_busy, 0);
    repeat (12) @(negedge in_clk);
  endtask

  typedef struct {
    int          npush;
    logic [31:0] w;
    int          len;
    int          exp_sent;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vec_t v;
    int s0, d0, r0, nrx;
    logic [7:0] b;

    vecs[0] = '{npush: 2, w: 32'hA53C_0000, len: 2,
                exp_sent: 2, exp_err: 1'b0, exp_done: 1};
    vecs[1] = '{npush: 0, w: 32'h0000_0000, len: 0,
                exp_sent: 0, exp_err: 1'b0, exp_done: 1};
    vecs[2] = '{npush: 1, w: 32'h1100_0000, len: 3,
                exp_sent: 1, exp_err: 1'b1, exp_done: 0};
    vecs[3] = '{npush: 3, w: 32'h0102_0300, len: 3,
                exp_sent: 3, exp_err: 1'b0, exp_done: 1};
    vecs[4] = '{npush: 4, w: 32'hDEAD_BEEF, len: 4,
                exp_sent: 4, exp_err: 1'b0, exp_done: 1};

    repeat (3) @(negedge in_clk);
    chk("rst_enable", out_enable, 0);
    chk("rst_word", out_word, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_done", out_done, 0);
    chk("rst_error", out_error, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_rxvalid", out_rx_valid, 0);
    chk("rst_rxdata", out_rx_data, 0);
    chk("rst_txready", out_tx_ready, 0);
    in_rst = 1'b1;
    @(negedge in_clk);
    chk("rel_txready", out_tx_ready, 1);

    for (int k = 0; k < 5; k++) begin
      v  = vecs[k];
      s0 = sent_q.size();
      d0 = done_cnt;
      r0 = rise_cnt;
      for (int i = 0; i < v.npush; i++) push(v.w[31-8*i -: 8]);
      start(v.len);
      if (v.len == 0) chk($sformatf("v%0d_done_next", k), out_done, 1);
      wait_idle($sformatf("v%0d", k));
      chk($sformatf("v%0d_sent", k), sent_q.size() - s0, v.exp_sent);
      for (int i = 0; i < v.exp_sent && s0 + i < sent_q.size(); i++)
        chk($sformatf("v%0d_word%0d", k, i), sent_q[s0+i], v.w[31-8*i -: 8]);
      chk($sformatf("v%0d_done", k), done_cnt - d0, v.exp_done);
      chk($sformatf("v%0d_error", k), out_error, v.exp_err);
      chk($sformatf("v%0d_enable", k), out_enable, 0);
      chk($sformatf("v%0d_rises", k), rise_cnt - r0, v.exp_sent > 0);
      nrx = v.exp_err ? 0 : v.exp_sent;
      for (int i = 0; i < nrx; i++)
        pop_chk($sformatf("v%0d_rx%0d", k, i), v.w[31-8*i -: 8]);
      chk($sformatf("v%0d_rxempty", k), out_rx_valid, 0);
    end

    // TX fill to depth, RX left unread so the fifth capture overflows
    s0 = sent_q.size();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push(8'(8'h10 * (i + 1)));
    chk("ovf_txfull", out_tx_ready, 0);
    start(5);
    chk("ovf_txfull_prime", out_tx_ready, 0);
    @(negedge in_clk);
    chk("ovf_txready_pop", out_tx_ready, 1);
    push(8'h50);
    wait_idle("ovf");
    chk("ovf_flag", out_overflow, 1);
    chk("ovf_done", done_cnt - d0, 1);
    chk("ovf_sent", sent_q.size() - s0, 5);
    for (int i = 0; i < 5 && s0 + i < sent_q.size(); i++) begin
      b = 8'(8'h10 * (i + 1));
      chk($sformatf("ovf_word%0d", i), sent_q[s0+i], b);
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h10 * (i + 1));
      pop_chk($sformatf("ovf_rx%0d", i), b);
    end
    chk("ovf_rxempty", out_rx_valid, 0);

    // Start strobe while busy must be ignored
    s0 = sent_q.size();
    d0 = done_cnt;
    r0 = rise_cnt;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    start(3);
    chk("bs_ovf_clear", out_overflow, 0);
    repeat (20) @(negedge in_clk);
    chk("bs_busy", out_busy, 1);
    start(1);
    wait_idle("bs");
    chk("bs_sent", sent_q.size() - s0, 3);
    chk("bs_done", done_cnt - d0, 1);
    chk("bs_rises", rise_cnt - r0, 1);
    pop_chk("bs_rx0", 8'hC1);
    pop_chk("bs_rx1", 8'hC2);
    pop_chk("bs_rx2", 8'hC3);
    chk("bs_rxempty", out_rx_valid, 0);

    // Reset during the second word of a four-word burst
    s0 = sent_q.size();
    for (int i = 0; i < 4; i++) push(8'(8'hA1 + i));
    start(4);
    begin
      int n = 0;
      while (sent_q.size() < s0 + 2 && n < 2000) begin
        @(negedge in_clk);
        n++;
      end
    end
    chk("mr_word2", sent_q.size() - s0, 2);
    chk("mr_enable_before", out_enable, 1);
    in_rst = 1'b0;
    @(negedge in_clk);
    chk("mr_enable", out_enable, 0);
    chk("mr_busy", out_busy, 0);
    chk("mr_rxvalid", out_rx_valid, 0);
    chk("mr_txready_rst", out_tx_ready, 0);
    repeat (2) @(negedge in_clk);
    chk("mr_txready_hold", out_tx_ready, 0);
    in_rst = 1'b1;
    @(negedge in_clk);
    chk("mr_txready_rel", out_tx_ready, 1);
    chk("mr_rxvalid_rel", out_rx_valid, 0);
    repeat (40) @(negedge in_clk);
    chk("mr_no_restart", out_enable, 0);
    chk("mr_fsm_idle", out_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
